// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch front end: address/word aliases, queue entry and FSM state.
// Combinational helpers only; no latency or backpressure.
// Imported by the interface, the entry FIFO and the top.
package fetch_queue_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        addr_t pc;
        word_t instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_HOLD
    } fetch_state_e;

    localparam addr_t PC_STEP = 32'd4;

    function automatic addr_t align_pc(input addr_t pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of fetch control, ICache request/response and decode handshake signals.
// No latency; pure wiring.
// master = fetch_queue side, slave = ICache/decode/branch-unit side.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic  fetch_en_i;
    logic  redirect_valid_i;
    addr_t redirect_pc_i;
    logic  ic_req_valid_o;
    addr_t ic_req_pc_o;
    logic  ic_req_ready_i;
    logic  ic_rsp_valid_i;
    word_t ic_rsp_instr_i;
    logic  dec_valid_o;
    addr_t dec_pc_o;
    word_t dec_instr_o;
    logic  dec_ready_i;

    modport master (
        input  fetch_en_i, redirect_valid_i, redirect_pc_i,
        input  ic_req_ready_i, ic_rsp_valid_i, ic_rsp_instr_i, dec_ready_i,
        output ic_req_valid_o, ic_req_pc_o, dec_valid_o, dec_pc_o, dec_instr_o
    );

    modport slave (
        output fetch_en_i, redirect_valid_i, redirect_pc_i,
        output ic_req_ready_i, ic_rsp_valid_i, ic_rsp_instr_i, dec_ready_i,
        input  ic_req_valid_o, ic_req_pc_o, dec_valid_o, dec_pc_o, dec_instr_o
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous in-order FIFO of fetch entries with clear and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    output fetch_entry_t                 head_dat,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            count <= '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear) mem[wr_q] <= push_dat;
    end

    assign head_dat = mem[rd_q];
    assign empty    = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PCs, ICache requests, in-order queue to decode; FETCH_QUEUE_BYPASS_EN adds same-cycle bypass.
// Latency: a response reaches dec_* one cycle after it returns (same cycle via bypass when queue is empty).
// Backpressure: requests stall while in-flight plus queued entries would exceed DEPTH; redirects flush and drop in-flight responses.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int    DEPTH           = 4,
    parameter int    MAX_OUTSTANDING = 2,
    parameter addr_t RESET_PC        = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    fetch_state_e  state_q, state_d;
    addr_t         fetch_pc_q;
    logic [OW-1:0] outstanding_q, outstanding_d, drop_cnt_q;
    addr_t         tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0] tag_wr_q, tag_rd_q;

    logic          req_acc, rsp_keep, q_push, q_pop, q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_head, rsp_entry, dec_entry;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.ic_req_valid_o = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN: begin
                if (!bus.fetch_en_i) state_d = ST_HOLD;
                // Each request reserves a queue slot so responses always find room.
                bus.ic_req_valid_o = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                                     (int'(q_count) + int'(outstanding_q) < DEPTH);
            end
            ST_HOLD:  if (bus.fetch_en_i) state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    assign bus.ic_req_pc_o = fetch_pc_q;
    assign req_acc         = bus.ic_req_valid_o && bus.ic_req_ready_i;
    assign outstanding_d   = outstanding_q + OW'(req_acc) - OW'(bus.ic_rsp_valid_i);
    assign rsp_entry       = '{pc: tag_mem[tag_rd_q], instr: bus.ic_rsp_instr_i};
    assign rsp_keep        = bus.ic_rsp_valid_i && (drop_cnt_q == '0) && !bus.redirect_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (bus.redirect_valid_i) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc_q <= align_pc(bus.redirect_pc_i);
                drop_cnt_q <= outstanding_d;
            end else begin
                if (req_acc) fetch_pc_q <= fetch_pc_q + PC_STEP;
                if (bus.ic_rsp_valid_i && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - OW'(1);
            end
            if (req_acc)            tag_wr_q <= (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
            if (bus.ic_rsp_valid_i) tag_rd_q <= (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_acc) tag_mem[tag_wr_q] <= fetch_pc_q;
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass          = q_empty && (drop_cnt_q == '0) && bus.ic_rsp_valid_i;
    assign bus.dec_valid_o = !q_empty || bypass;
    assign dec_entry       = !q_empty ? q_head : (bypass ? rsp_entry : '0);
    assign q_push          = rsp_keep && !(bypass && bus.dec_ready_i);
    assign q_pop           = !q_empty && bus.dec_ready_i && !bus.redirect_valid_i;
`else
    assign bus.dec_valid_o = !q_empty;
    assign dec_entry       = q_empty ? '0 : q_head;
    assign q_push          = rsp_keep;
    assign q_pop           = bus.dec_valid_o && bus.dec_ready_i && !bus.redirect_valid_i;
`endif

    assign bus.dec_pc_o    = dec_entry.pc;
    assign bus.dec_instr_o = dec_entry.instr;

    fetch_queue_fifo #(.DEPTH(DEPTH)) u_entry_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (bus.redirect_valid_i),
        .push     (q_push),
        .push_dat (rsp_entry),
        .pop      (q_pop),
        .head_dat (q_head),
        .empty    (q_empty),
        .count    (q_count)
    );

endmodule
